ls191_chain: RTL and testbench
==============================

LS191_CHAIN -- requirements
Module: ls191_chain

Interface
REQ-001 The block SHALL provide parameter STAGES, default 2: number of cascaded 4-bit 74LS191-style slices; legal range 1..8.
REQ-002 Port clk, input, 1 bit: the single system clock.
REQ-003 Port reset, input, 1 bit: reset, synchronous and active-high.
REQ-004 Port cen, input, 1 bit: clock enable; an asserted cen on a clk edge emulates one rising edge of the chip clock.
REQ-005 Port n_cten, input, 1 bit: count enable, active-low.
REQ-006 Port d_u, input, 1 bit: count direction; 0 counts up, 1 counts down.
REQ-007 Port n_load, input, 1 bit: parallel load, active-low, synchronous.
REQ-008 Port din, input, 4*STAGES bits: parallel load data; bits [3:0] are slice 0, the least significant slice.
REQ-009 Port q, output, 4*STAGES bits: counter value.
REQ-010 Port max_min, output, 1 bit: terminal-count flag of the most significant slice.
REQ-011 Port n_rco, output, 1 bit: ripple-clock strobe of the most significant slice, active-low.

Function
REQ-012 State SHALL change only on a clk edge, and only when reset or cen is high.
REQ-013 Priority on a clk edge with cen high SHALL be: reset, then load, then count, then hold.
REQ-014 Load: when n_load=0, q SHALL become din on that edge, regardless of n_cten and d_u.
REQ-015 Count: when n_load=1 and n_cten=0, q SHALL become q+1 (d_u=0) or q-1 (d_u=1), modulo 2^(4*STAGES).
REQ-016 Hold: when n_load=1 and n_cten=1, q SHALL hold its value.
REQ-017 Cascade: slice k SHALL count only when n_cten=0 and every lower slice is at its terminal value (0xF when counting up, 0x0 when counting down).
REQ-018 Slice terminal flag SHALL be (d_u=0 and slice=0xF) or (d_u=1 and slice=0x0). It is combinational, independent of n_cten, and follows d_u changes in the same cycle.
REQ-019 max_min SHALL equal the terminal flag of slice STAGES-1 ANDed with the terminal flags of all lower slices, so it marks a whole-word terminal value.
REQ-020 n_rco SHALL be 0 exactly when max_min=1, n_cten=0 and cen=1; otherwise it is 1. It is a one-cen strobe usable as the enable of a further chain.
REQ-021 Wrap-around: up from all-ones SHALL give 0; down from 0 SHALL give all-ones. No sticky flags.
REQ-022 A direction change SHALL take effect on the next counting edge, with no lost or extra count.
REQ-023 Load and count asserted together SHALL load only.
REQ-024 With cen low, inputs SHALL have no effect on q, and n_rco SHALL stay 1.

Reset
REQ-025 While reset=1 on a clk edge, q SHALL become 0 whether or not cen is high; reset overrides load.
REQ-026 n_rco SHALL be forced to 1 while reset=1.
REQ-027 After reset, max_min SHALL be 1 if d_u=1 and 0 if d_u=0.
REQ-028 A reset arriving mid-count SHALL take effect on that same edge, with no pending count retained.

Structure
REQ-029 The 4-bit slice SHALL be one sub-module, ls191_slice. Its ports are clk, reset, cen, cnt_en, d_u, n_load, din[3:0], q[3:0] and term. The chain generates STAGES instances of it and an AND-chain of term signals.
REQ-030 A shared package SHALL hold the constants SLICE_W=4, TERM_UP=4'hF and TERM_DN=4'h0, and the direction encoding DIR_UP=0 and DIR_DN=1.
REQ-031 The block SHALL contain no asynchronous logic, no gated clocks and no latches.

Verification (STAGES=2)
REQ-032 Reset: assert reset with cen=0, d_u=1 -> q=0x00 after one clk, max_min=1, n_rco=1.
REQ-033 Up count: load din=0xFD, then n_cten=0, d_u=0, cen=1 for 3 edges -> q goes 0xFE, 0xFF, 0x00. max_min=1 only while q=0xFF; n_rco=0 on that cycle only.
REQ-034 Down count: load din=0x01, then d_u=1, 3 counting edges -> q goes 0x00, 0xFF, 0xFE. max_min=1 only at 0x00.
REQ-035 Priority: q=0x3C; on one edge set n_load=0 with din=0x5A, n_cten=0, cen=1 -> q=0x5A. Next edge adds reset=1 with n_load=0 -> q=0x00.
REQ-036 Enable gating: q=0x0F, n_cten=0, cen toggling 1 of 3 clocks for 6 clocks -> q=0x11. n_rco=1 whenever cen=0.
REQ-037 Direction flip: q=0x10, count down 1 edge, then d_u=0 for 1 edge -> q goes 0x0F, then 0x10. max_min follows d_u in the same cycle with no edge needed.

Source files
------------

// File: rtl/ls191_chain_pkg.sv
// ---------------------------------------------------------------------------
// ls191_chain_pkg
// Constants shared by the 74LS191-style counter chain and its slices:
//   SLICE_W  - width of one counter slice
//   TERM_UP  - slice value that is terminal when counting up
//   TERM_DN  - slice value that is terminal when counting down
//   DIR_UP / DIR_DN - encoding of the d_u direction input
// ---------------------------------------------------------------------------
package ls191_chain_pkg;

    localparam int         SLICE_W = 4;
    localparam logic [3:0] TERM_UP = 4'hF;
    localparam logic [3:0] TERM_DN = 4'h0;
    localparam logic       DIR_UP  = 1'b0;
    localparam logic       DIR_DN  = 1'b1;

endpackage : ls191_chain_pkg

// File: rtl/ls191_slice.sv
// ---------------------------------------------------------------------------
// ls191_slice
// One 4-bit up/down counter slice modelled on a 74LS191, re-timed onto a
// system clock with a clock enable.
// Ports:
//   clk     - system clock
//   reset   - synchronous active-high reset, acts even when cen is low
//   cen     - clock enable; one asserted cycle emulates one chip clock edge
//   cnt_en  - count enable for this slice (already includes the cascade)
//   d_u     - direction, DIR_UP counts up, DIR_DN counts down
//   n_load  - active-low synchronous parallel load, wins over counting
//   din     - parallel load data
//   q       - slice value
//   term    - combinational terminal-value flag for the current direction
// ---------------------------------------------------------------------------
module ls191_slice
    import ls191_chain_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               cen,
    input  logic               cnt_en,
    input  logic               d_u,
    input  logic               n_load,
    input  logic [SLICE_W-1:0] din,
    output logic [SLICE_W-1:0] q,
    output logic               term
);

    logic [SLICE_W-1:0] q_reg;
    logic [SLICE_W-1:0] q_next;

    always_comb begin
        q_next = q_reg;
        if (!n_load) begin
            q_next = din;
        end else if (cnt_en) begin
            if (d_u == DIR_DN) begin
                q_next = q_reg - 4'd1;
            end else begin
                q_next = q_reg + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_reg <= '0;
        end else if (cen) begin
            q_reg <= q_next;
        end
    end

    // Terminal flag tracks d_u immediately, so a direction change is
    // visible on the flag before the next counting edge.
    assign term = ((d_u == DIR_UP) && (q_reg == TERM_UP)) ||
                  ((d_u == DIR_DN) && (q_reg == TERM_DN));

    assign q = q_reg;

endmodule : ls191_slice

// File: rtl/ls191_chain.sv
// ---------------------------------------------------------------------------
// ls191_chain
// STAGES cascaded 4-bit 74LS191-style slices forming a 4*STAGES-bit
// synchronous up/down counter with parallel load.
// Ports:
//   clk     - system clock
//   reset   - synchronous active-high reset (q -> 0, overrides load)
//   cen     - clock enable, emulates the chip clock edge
//   n_cten  - active-low count enable
//   d_u     - direction: 0 up, 1 down
//   n_load  - active-low synchronous parallel load
//   din     - load data, bits [3:0] belong to the least significant slice
//   q       - counter value
//   max_min - whole-word terminal flag (all-ones up / all-zeros down)
//   n_rco   - active-low one-cen strobe when the whole word rolls over
// ---------------------------------------------------------------------------
module ls191_chain
    import ls191_chain_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       cen,
    input  logic                       n_cten,
    input  logic                       d_u,
    input  logic                       n_load,
    input  logic [SLICE_W*STAGES-1:0]  din,
    output logic [SLICE_W*STAGES-1:0]  q,
    output logic                       max_min,
    output logic                       n_rco
);

    // carry[k] is high when every slice below k sits at its terminal value;
    // carry[0] is tied high so the least significant slice always counts.
    logic [STAGES:0]   carry;
    logic [STAGES-1:0] term;

    assign carry[0] = 1'b1;

    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_slice
            ls191_slice u_slice (
                .clk    (clk),
                .reset  (reset),
                .cen    (cen),
                .cnt_en (~n_cten & carry[gi]),
                .d_u    (d_u),
                .n_load (n_load),
                .din    (din[gi*SLICE_W +: SLICE_W]),
                .q      (q[gi*SLICE_W +: SLICE_W]),
                .term   (term[gi])
            );

            assign carry[gi+1] = carry[gi] & term[gi];
        end
    endgenerate

    assign max_min = carry[STAGES];

    // Strobe lasts exactly the enabled cycle in which the word wraps, so it
    // can feed the cen of a further chain; held inactive during reset.
    assign n_rco = ~(max_min & ~n_cten & cen & ~reset);

endmodule : ls191_chain

// File: tb/tb_ls191_chain.sv
// ---------------------------------------------------------------------------
// tb_ls191_chain
// Directed test of ls191_chain with STAGES=2. Inputs change 1 ns after the
// rising edge, outputs are checked just before the next rising edge.
// ---------------------------------------------------------------------------
module tb_ls191_chain;

    logic       clk;
    logic       reset;
    logic       cen;
    logic       n_cten;
    logic       d_u;
    logic       n_load;
    logic [7:0] din;
    logic [7:0] q;
    logic       max_min;
    logic       n_rco;

    int checks;
    int failures;

    ls191_chain #(.STAGES(2)) dut (
        .clk     (clk),
        .reset   (reset),
        .cen     (cen),
        .n_cten  (n_cten),
        .d_u     (d_u),
        .n_load  (n_load),
        .din     (din),
        .q       (q),
        .max_min (max_min),
        .n_rco   (n_rco)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end else begin
            $display("ok   %s value=%0h", tag, got);
        end
    endtask

    // Advance one clock; inputs may be changed on return.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Check all outputs a little before the next rising edge.
    task automatic expect_state(input string tag, input logic [7:0] eq,
                                input logic emm, input logic erco);
        #3;
        check_val({tag, ".q"}, {24'h0, q}, {24'h0, eq});
        check_val({tag, ".max_min"}, {31'h0, max_min}, {31'h0, emm});
        check_val({tag, ".n_rco"}, {31'h0, n_rco}, {31'h0, erco});
    endtask

    logic [7:0] up_q   [3];
    logic       up_mm  [3];
    logic       up_rco [3];
    logic [7:0] dn_q   [3];
    logic       dn_mm  [3];
    logic       dn_rco [3];

    initial begin
        checks   = 0;
        failures = 0;
        up_q   = '{8'hFE, 8'hFF, 8'h00};
        up_mm  = '{1'b0, 1'b1, 1'b0};
        up_rco = '{1'b1, 1'b0, 1'b1};
        dn_q   = '{8'h00, 8'hFF, 8'hFE};
        dn_mm  = '{1'b1, 1'b0, 1'b0};
        dn_rco = '{1'b0, 1'b1, 1'b1};

        reset  = 1'b1;
        cen    = 1'b0;
        n_cten = 1'b1;
        d_u    = 1'b1;
        n_load = 1'b1;
        din    = 8'h00;
        #1;

        // Reset with cen low, counting down selected.
        step();
        expect_state("reset", 8'h00, 1'b1, 1'b1);
        reset = 1'b0;

        // Up count from 0xFD through the wrap.
        step();
        cen = 1'b1; n_load = 1'b0; din = 8'hFD;
        step();
        n_load = 1'b1; n_cten = 1'b0; d_u = 1'b0;
        expect_state("up_start", 8'hFD, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step();
            expect_state($sformatf("up%0d", i), up_q[i], up_mm[i], up_rco[i]);
        end

        // Load beats count; then count down through the wrap.
        n_load = 1'b0; din = 8'h01;
        step();
        n_load = 1'b1; d_u = 1'b1;
        expect_state("dn_start", 8'h01, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step();
            expect_state($sformatf("dn%0d", i), dn_q[i], dn_mm[i], dn_rco[i]);
        end

        // Priority: load over count, reset over load.
        n_load = 1'b0; din = 8'h3C;
        step();
        din = 8'h5A;
        step();
        expect_state("prio_load", 8'h5A, 1'b0, 1'b1);
        reset = 1'b1;
        step();
        // q=0, d_u=1, n_cten=0, cen=1 would strobe, but reset masks it.
        expect_state("prio_reset", 8'h00, 1'b1, 1'b1);
        reset = 1'b0;

        // Enable gating: cen high one clock in three for six clocks.
        din = 8'h0F;
        step();
        n_load = 1'b1; d_u = 1'b0; n_cten = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cen = (i % 3 == 0);
            if (!cen) begin
                #3;
                check_val($sformatf("gate_rco%0d", i), {31'h0, n_rco}, 32'h1);
            end
            step();
        end
        expect_state("gate_q", 8'h11, 1'b0, 1'b1);

        // cen low: load request ignored.
        cen = 1'b0; n_load = 1'b0; din = 8'hAA;
        step();
        expect_state("cen_low_load", 8'h11, 1'b0, 1'b1);

        // Direction flip: 0x10 down to 0x0F, then up back to 0x10.
        cen = 1'b1; din = 8'h10;
        step();
        n_load = 1'b1; d_u = 1'b1;
        step();
        expect_state("flip_dn", 8'h0F, 1'b0, 1'b1);
        d_u = 1'b0;
        step();
        expect_state("flip_up", 8'h10, 1'b0, 1'b1);

        // max_min follows d_u without a clock edge; hold with n_cten high.
        n_load = 1'b0; din = 8'hFF; n_cten = 1'b1;
        step();
        n_load = 1'b1;
        expect_state("mm_up", 8'hFF, 1'b1, 1'b1);
        d_u = 1'b1;
        expect_state("mm_dn", 8'hFF, 1'b0, 1'b1);
        step();
        expect_state("hold", 8'hFF, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_ls191_chain
